// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS-lite multi-cycle controller: instruction
// fields, datapath select codes, FSM states and the packed control word.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_OR    = 3'b010;
    localparam logic [2:0] ALU_PASSB = 3'b011;

    localparam logic [1:0] EXT_ZERO = 2'b00;
    localparam logic [1:0] EXT_SIGN = 2'b01;
    localparam logic [1:0] EXT_HIGH = 2'b10;

    localparam logic [1:0] NPC_SEQ = 2'b00;
    localparam logic [1:0] NPC_BR  = 2'b01;
    localparam logic [1:0] NPC_JMP = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_EXE_R,
        S_EXE_I,
        S_MEM_ADR,
        S_MEM_RD,
        S_MEM_WB,
        S_MEM_WR,
        S_WB_R,
        S_WB_I,
        S_BRANCH,
        S_JUMP
    } state_t;

    typedef struct packed {
        logic       pc_wr;
        logic       ir_wr;
        logic       reg_write;
        logic       mem_write;
        logic       mem_read;
        logic       alu_src;
        logic       mem_to_reg;
        logic       reg_dst;
        logic [1:0] ext_op;
        logic [2:0] alu_op;
        logic [1:0] npc_sel;
        logic       retire;
        logic       illegal;
    } ctrl_t;

    localparam int CTRL_W = $bits(ctrl_t);

    function automatic logic is_legal(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            OP_RTYPE: return (fn == FN_ADDU) || (fn == FN_SUBU);
            OP_ORI, OP_LUI, OP_LW, OP_SW, OP_BEQ, OP_J: return 1'b1;
            default:  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mips_mc_outdec.sv
// Combinational control-word decoder: current state plus instruction fields
// to every datapath enable and select. run = 0 forces the whole word to 0.
module mips_mc_outdec
    import mips_pkg::*;
(
    input  logic [3:0]        state,
    input  logic [5:0]        opcode,
    input  logic [5:0]        funct,
    input  logic              zero,
    input  logic              run,
    output logic [CTRL_W-1:0] ctrl
);

    ctrl_t c;

    always_comb begin
        c = '0;
        case (state_t'(state))
            S_FETCH: begin
                c.ir_wr   = 1'b1;
                c.pc_wr   = 1'b1;
                c.npc_sel = NPC_SEQ;
            end
            S_DECODE: begin
                if (!is_legal(opcode, funct)) begin
                    c.illegal = 1'b1;
                    c.retire  = 1'b1;
                end
            end
            S_EXE_R, S_WB_R: begin
                c.alu_op = (funct == FN_SUBU) ? ALU_SUB : ALU_ADD;
                if (state_t'(state) == S_WB_R) begin
                    c.reg_write = 1'b1;
                    c.reg_dst   = 1'b1;
                    c.retire    = 1'b1;
                end
            end
            S_EXE_I, S_WB_I: begin
                c.alu_src = 1'b1;
                if (opcode == OP_LUI) begin
                    c.ext_op = EXT_HIGH;
                    c.alu_op = ALU_PASSB;
                end else begin
                    c.ext_op = EXT_ZERO;
                    c.alu_op = ALU_OR;
                end
                if (state_t'(state) == S_WB_I) begin
                    c.reg_write = 1'b1;
                    c.retire    = 1'b1;
                end
            end
            // address path stays selected while memory is accessed
            S_MEM_ADR, S_MEM_RD, S_MEM_WR: begin
                c.alu_src = 1'b1;
                c.ext_op  = EXT_SIGN;
                c.alu_op  = ALU_ADD;
                c.mem_read  = (state_t'(state) == S_MEM_RD);
                c.mem_write = (state_t'(state) == S_MEM_WR);
                c.retire    = (state_t'(state) == S_MEM_WR);
            end
            S_MEM_WB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
                c.retire     = 1'b1;
            end
            S_BRANCH: begin
                c.alu_op  = ALU_SUB;
                c.npc_sel = NPC_BR;
                c.pc_wr   = zero;
                c.retire  = 1'b1;
            end
            S_JUMP: begin
                c.npc_sel = NPC_JMP;
                c.pc_wr   = 1'b1;
                c.retire  = 1'b1;
            end
            default: ;
        endcase
        if (!run) c = '0;
    end

    assign ctrl = c;

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle control FSM for the MIPS-lite core: state register and
// next-state logic; the control word comes from mips_mc_outdec.
//
//   state     | meaning
//   ----------+-----------------------------------------------
//   FETCH     | load IR, PC <= PC+4
//   DECODE    | classify opcode/funct, flag unsupported ones
//   EXE_R     | ALU add/sub on RD1, RD2
//   WB_R      | write ALU result to rd
//   EXE_I     | ALU or/pass-B on extended immediate
//   WB_I      | write ALU result to rt
//   MEM_ADR   | base + sign-extended offset
//   MEM_RD    | data-memory read
//   MEM_WB    | write memory data to rt
//   MEM_WR    | data-memory write
//   BRANCH    | compare, take branch if zero
//   JUMP      | load jump target
module mips_mc_ctrl
    import mips_pkg::*;
#(
    parameter int OP_W    = 6,
    parameter int FN_W    = 6,
    parameter int ALUOP_W = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [OP_W-1:0]    opcode,
    input  logic [FN_W-1:0]    funct,
    input  logic               zero,
    output logic               pc_wr,
    output logic               ir_wr,
    output logic               RegWrite,
    output logic               MemWrite,
    output logic               MemRead,
    output logic               ALUsrc,
    output logic               MemtoReg,
    output logic               RegDst,
    output logic [1:0]         ext_op,
    output logic [ALUOP_W-1:0] alu_op,
    output logic [1:0]         npc_sel,
    output logic               retire,
    output logic               illegal
);

    state_t            state, state_nx;
    logic [CTRL_W-1:0] ctrl_bits;
    ctrl_t             ctrl;

    always_ff @(posedge clk) begin
        if (!rst) state <= S_FETCH;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = S_FETCH;
        case (state)
            S_FETCH:   state_nx = S_DECODE;
            S_DECODE: begin
                if (is_legal(opcode, funct)) begin
                    case (opcode)
                        OP_RTYPE:       state_nx = S_EXE_R;
                        OP_ORI, OP_LUI: state_nx = S_EXE_I;
                        OP_LW, OP_SW:   state_nx = S_MEM_ADR;
                        OP_BEQ:         state_nx = S_BRANCH;
                        OP_J:           state_nx = S_JUMP;
                        default:        state_nx = S_FETCH;
                    endcase
                end
            end
            S_EXE_R:   state_nx = S_WB_R;
            S_EXE_I:   state_nx = S_WB_I;
            S_MEM_ADR: state_nx = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:  state_nx = S_MEM_WB;
            default:   state_nx = S_FETCH;
        endcase
    end

    mips_mc_outdec u_outdec (
        .state  (state),
        .opcode (opcode),
        .funct  (funct),
        .zero   (zero),
        .run    (rst),
        .ctrl   (ctrl_bits)
    );

    assign ctrl     = ctrl_t'(ctrl_bits);
    assign pc_wr    = ctrl.pc_wr;
    assign ir_wr    = ctrl.ir_wr;
    assign RegWrite = ctrl.reg_write;
    assign MemWrite = ctrl.mem_write;
    assign MemRead  = ctrl.mem_read;
    assign ALUsrc   = ctrl.alu_src;
    assign MemtoReg = ctrl.mem_to_reg;
    assign RegDst   = ctrl.reg_dst;
    assign ext_op   = ctrl.ext_op;
    assign alu_op   = ctrl.alu_op;
    assign npc_sel  = ctrl.npc_sel;
    assign retire   = ctrl.retire;
    assign illegal  = ctrl.illegal;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Bench for mips_mc_ctrl: directed and random instructions, each cycle's
// control outputs compared against a per-instruction cycle-table model.
module tb_mips_mc_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       pc_wr, ir_wr, RegWrite, MemWrite, MemRead, ALUsrc, MemtoReg, RegDst;
    logic [1:0] ext_op, npc_sel;
    logic [2:0] alu_op;
    logic       retire, illegal;

    int checks = 0;
    int errors = 0;

    mips_mc_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .opcode   (opcode),
        .funct    (funct),
        .zero     (zero),
        .pc_wr    (pc_wr),
        .ir_wr    (ir_wr),
        .RegWrite (RegWrite),
        .MemWrite (MemWrite),
        .MemRead  (MemRead),
        .ALUsrc   (ALUsrc),
        .MemtoReg (MemtoReg),
        .RegDst   (RegDst),
        .ext_op   (ext_op),
        .alu_op   (alu_op),
        .npc_sel  (npc_sel),
        .retire   (retire),
        .illegal  (illegal)
    );

    always #5 clk = ~clk;

    logic [16:0] obs;
    assign obs = {pc_wr, ir_wr, RegWrite, MemWrite, MemRead, ALUsrc, MemtoReg, RegDst,
                  ext_op, alu_op, npc_sel, retire, illegal};

    function automatic logic legal(input logic [5:0] op, input logic [5:0] fn);
        if (op == 6'd0) return (fn == 6'b100001) || (fn == 6'b100011);
        return op inside {6'b001101, 6'b001111, 6'b100011, 6'b101011, 6'b000100, 6'b000010};
    endfunction

    function automatic int n_cycles(input logic [5:0] op, input logic [5:0] fn);
        if (!legal(op, fn)) return 2;
        if (op == 6'b000100 || op == 6'b000010) return 3;
        if (op == 6'b100011) return 5;
        return 4;
    endfunction

    // expected outputs for cycle cyc (1 = fetch) of instruction op/fn
    function automatic logic [16:0] model(input logic [5:0] op, input logic [5:0] fn,
                                          input int cyc, input logic z);
        logic pc, ir, rw, mw, mr, as, m2r, rd, ret, ill;
        logic [1:0] ext, npc;
        logic [2:0] alu;
        {pc, ir, rw, mw, mr, as, m2r, rd, ret, ill} = '0;
        ext = 2'd0; npc = 2'd0; alu = 3'd0;
        if (cyc == 1) begin
            pc = 1'b1; ir = 1'b1;
        end else if (cyc == 2) begin
            if (!legal(op, fn)) begin ill = 1'b1; ret = 1'b1; end
        end else if (op == 6'd0) begin
            alu = (fn == 6'b100011) ? 3'd1 : 3'd0;
            if (cyc == 4) begin rw = 1'b1; rd = 1'b1; ret = 1'b1; end
        end else if (op == 6'b001101 || op == 6'b001111) begin
            as  = 1'b1;
            ext = (op == 6'b001111) ? 2'b10 : 2'b00;
            alu = (op == 6'b001111) ? 3'd3 : 3'd2;
            if (cyc == 4) begin rw = 1'b1; ret = 1'b1; end
        end else if (op == 6'b100011 || op == 6'b101011) begin
            if (cyc <= 4) begin as = 1'b1; ext = 2'b01; end
            if (cyc == 4 && op == 6'b100011) mr = 1'b1;
            if (cyc == 4 && op == 6'b101011) begin mw = 1'b1; ret = 1'b1; end
            if (cyc == 5) begin rw = 1'b1; m2r = 1'b1; ret = 1'b1; end
        end else if (op == 6'b000100) begin
            alu = 3'd1; npc = 2'b01; pc = z; ret = 1'b1;
        end else begin
            npc = 2'b10; pc = 1'b1; ret = 1'b1;
        end
        return {pc, ir, rw, mw, mr, as, m2r, rd, ext, alu, npc, ret, ill};
    endfunction

    task automatic check(input string tag, input logic [16:0] o, input logic [16:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%05h expected=%05h", tag, o, e);
        end
    endtask

    // Entered at posedge+1 of a FETCH cycle; returns at posedge+1 of the next one.
    // zsel < 0 randomises zero; abort_cyc > 0 pulls rst low after that cycle.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input string tag,
                             input int zsel, input int abort_cyc);
        int n = n_cycles(op, fn);
        int rets = 0;
        opcode = op;
        funct  = fn;
        for (int c = 1; c <= n; c++) begin
            zero = (zsel < 0) ? 1'($urandom) : 1'(zsel);
            #1;
            check($sformatf("%s_c%0d", tag, c), obs, model(op, fn, c, zero));
            rets += int'(retire);
            if (c == abort_cyc) begin
                #1 rst = 1'b0;
                #1 check($sformatf("%s_abort_now", tag), obs, 17'd0);
                @(posedge clk); #1;
                check($sformatf("%s_abort_hold", tag), obs, 17'd0);
                rst = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        checks++;
        assert (rets === ((abort_cyc > 0) ? 0 : 1)) else begin
            errors++;
            $error("FAIL %s_retire_count observed=%0d expected=%0d", tag, rets,
                   (abort_cyc > 0) ? 0 : 1);
        end
    endtask

    initial begin
        logic [5:0] ops [9];
        logic [5:0] rop, rfn;
        int k;
        ops = '{6'b000000, 6'b000000, 6'b001101, 6'b001111, 6'b100011,
                6'b101011, 6'b000100, 6'b000010, 6'b111111};
        rst = 1'b0; opcode = 6'd0; funct = 6'd0; zero = 1'b1;
        #1 check("reset_0", obs, 17'd0);
        @(posedge clk); #1 check("reset_1", obs, 17'd0);
        @(posedge clk); #1 check("reset_2", obs, 17'd0);
        rst = 1'b1;

        run_instr(6'b000000, 6'b100001, "addu",  -1, 0);
        run_instr(6'b000000, 6'b100011, "subu",  -1, 0);
        run_instr(6'b001101, 6'b010101, "ori",   -1, 0);
        run_instr(6'b001111, 6'b000000, "lui",   -1, 0);
        run_instr(6'b100011, 6'b000000, "lw",    -1, 0);
        run_instr(6'b101011, 6'b000000, "sw",    -1, 0);
        run_instr(6'b000100, 6'b000000, "beq_t",  1, 0);
        run_instr(6'b000100, 6'b000000, "beq_nt", 0, 0);
        run_instr(6'b000010, 6'b000000, "j",     -1, 0);
        run_instr(6'b111111, 6'b100001, "ill_op", -1, 0);
        run_instr(6'b000000, 6'b100000, "ill_fn", -1, 0);
        run_instr(6'b100011, 6'b000000, "lw_abort", -1, 4);
        run_instr(6'b000000, 6'b100001, "post_abort", -1, 0);

        for (int i = 0; i < 60; i++) begin
            k = $urandom_range(0, 9);
            if (k == 9) begin
                rop = 6'($urandom);
                rfn = 6'($urandom);
            end else begin
                rop = ops[k];
                rfn = 6'($urandom);
                if (k == 0) rfn = 6'b100001;
                if (k == 1) rfn = 6'b100011;
            end
            run_instr(rop, rfn, $sformatf("rnd%0d", i), -1, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
